fifo_burst_reader: RTL
======================

// Module: fifo_burst_reader
// PURPOSE
//  Drains the read side of the first-word-fall-through FIFO and regroups its words into bounded bursts for the DMA write engine.
//  Each burst is announced with a request/length handshake, then streamed with valid/ready and a last flag.
//  Full bursts are sent when the FIFO reports enough data. A partial-fill timeout flushes stragglers as 1-word bursts.
//  Runs entirely in the FIFO read-clock domain, directly downstream of the FIFO.
// PARAMETERS
//  NBITS      64   data width, 1..72 (matches FIFO)
//  MAX_BURST  16   words per full burst, 2..16 (must not exceed FIFO almost-empty offset)
//  TIMEOUT    256  idle cycles with data present but almost-empty before single-word flush, 1..65535
// PORTS
//  clock             in   1      FIFO read clock
//  reset             in   1      synchronous, active-low (0 = reset)
//  fifo_data         in   NBITS  FIFO head word (FWFT)
//  fifo_valid        in   1      FIFO not empty
//  fifo_almost_empty in   1      FIFO holds < MAX_BURST words
//  fifo_read         out  1      pop FIFO head this cycle
//  req_valid         out  1      burst request pending
//  req_len           out  5      burst length in words, 1..MAX_BURST
//  req_ready         in   1      request accepted
//  o_data            out  NBITS  burst data (registered)
//  o_valid           out  1      o_data valid
//  o_last            out  1      final word of burst
//  o_ready           in   1      downstream accepts o_data
//  stat_words        out  32     total words sent (STATS_EN only; else tied 0)
//  stat_bursts       out  32     total bursts completed (STATS_EN only; else tied 0)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; req_valid=o_valid=o_last=fifo_read=0; req_len=0; timer=0; remain=0; stats=0.
//  Reset mid-burst aborts: in-flight o_data is discarded and the request is dropped. The FIFO is reset by its owner.
//  IDLE:
//   - If fifo_almost_empty==0: req_len<=MAX_BURST, req_valid<=1, go to REQ, timer<=0.
//   - Else if fifo_valid && timer==TIMEOUT-1: req_len<=1, req_valid<=1, go to REQ, timer<=0.
//   - Else timer increments while fifo_valid&&fifo_almost_empty; otherwise timer<=0.
//   - Full-burst condition has priority over timeout in the same cycle.
//  REQ: req_valid and req_len are held stable until req_valid&&req_ready.
//   - On accept: req_valid<=0, remain<=req_len, go to STREAM.
//   - Acceptance is one cycle; req_ready is ignored outside REQ.
//  STREAM:
//   - load = fifo_valid && remain!=0 && (!o_valid || o_ready); fifo_read=load (combinational).
//   - On load: o_data<=fifo_data, o_valid<=1, o_last<=(remain==1), remain<=remain-1.
//   - On o_valid&&o_ready&&!load: o_valid<=0, o_last<=0.
//   - Data latency is 1 cycle from FIFO head to o_data. Full throughput is 1 word/cycle when o_ready=1.
//   - o_data/o_last are held stable while o_valid&&!o_ready.
//   - On o_valid&&o_ready&&o_last: go to IDLE.
//  fifo_read is never asserted with fifo_valid==0, nor outside STREAM.
//  FIFO underrun mid-burst (fifo_valid drops) stalls with o_valid low. The burst is never truncated.
//  Stat counters wrap modulo 2^32.
// CONFIGURATION
//  FIFO_BURST_READER_STATS_EN defined:
//   - stat_words increments on each o_valid&&o_ready.
//   - stat_bursts increments on each o_valid&&o_ready&&o_last.
//  Undefined: counters are not built; stat_words=stat_bursts=0 constant.
// TESTING
//  1. Reset=0 for 3 cycles with fifo_valid=1, almost_empty=0 -> all outputs 0, fifo_read=0 throughout.
//  2. FIFO preloaded with 20 words 0..19, o_ready=1, req_ready=1 one cycle after req_valid -> req_len=16.
//     Then 16 consecutive o_valid beats 0..15, o_last on 15; words 16..19 remain queued.
//  3. 3 words, almost_empty=1, TIMEOUT=8 -> req_len=1 after 8 cycles; three 1-word bursts, each o_last=1.
//  4. Full burst with o_ready toggling 1/0 each cycle -> o_data stable while stalled.
//     16 words delivered in order, no duplicates or drops.
//  5. fifo_valid deasserted after word 5 for 10 cycles -> o_valid low after word 5 drains.
//     Resume yields words 6..15, single o_last.
//  6. Reset asserted mid-STREAM at word 7 -> next cycle o_valid=0, state IDLE.
//     With STATS_EN: after two full bursts stat_words=32, stat_bursts=2.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// Bundle of the FIFO read port, the burst request channel and the burst data
// channel of fifo_burst_reader; master is the reader, slave is its environment.
interface fifo_burst_reader_if #(
    parameter int NBITS = 64
) ();
    // Handshake semantics: a transfer happens on the rising clock edge where
    // both valid and ready are high. Once valid is raised, the payload
    // (req_len, or o_data/o_last) stays stable and valid stays high until that
    // edge. ready may change freely and never waits for valid.
    logic [NBITS-1:0] fifo_data;
    logic             fifo_valid;
    logic             fifo_almost_empty;
    logic             fifo_read;

    logic             req_valid;
    logic [4:0]       req_len;
    logic             req_ready;

    logic [NBITS-1:0] o_data;
    logic             o_valid;
    logic             o_last;
    logic             o_ready;

    logic [31:0]      stat_words;
    logic [31:0]      stat_bursts;

    logic [1:0]       dbg_state;

    modport master (
        input  fifo_data, fifo_valid, fifo_almost_empty, req_ready, o_ready,
        output fifo_read, req_valid, req_len, o_data, o_valid, o_last,
               stat_words, stat_bursts, dbg_state
    );

    modport slave (
        output fifo_data, fifo_valid, fifo_almost_empty, req_ready, o_ready,
        input  fifo_read, req_valid, req_len, o_data, o_valid, o_last,
               stat_words, stat_bursts, dbg_state
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a FWFT FIFO into request-announced bursts with a timeout flush of stragglers.
// Optional word/burst counters are built when FIFO_BURST_READER_STATS_EN is defined.
module fifo_burst_reader #(
    parameter int NBITS     = 64,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 256
) (
    input  logic                clock,
    input  logic                reset,
    fifo_burst_reader_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam logic [4:0]  MAX_LEN      = 5'(MAX_BURST);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [15:0]      timer;
    logic [4:0]       remain;
    logic             load;
    logic             req_valid_q;
    logic [4:0]       req_len_q;
    logic [NBITS-1:0] o_data_q;
    logic             o_valid_q;
    logic             o_last_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            remain      <= '0;
            req_valid_q <= 1'b0;
            req_len_q   <= '0;
            o_data_q    <= '0;
            o_valid_q   <= 1'b0;
            o_last_q    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (!bus.fifo_almost_empty) begin
                        req_len_q   <= MAX_LEN;
                        req_valid_q <= 1'b1;
                        timer       <= '0;
                    end else if (bus.fifo_valid && timer == TIMEOUT_LAST) begin
                        req_len_q   <= 5'd1;
                        req_valid_q <= 1'b1;
                        timer       <= '0;
                    end else if (bus.fifo_valid) begin
                        timer <= timer + 16'd1;
                    end else begin
                        timer <= '0;
                    end
                end
                ST_REQ: begin
                    if (bus.req_ready) begin
                        req_valid_q <= 1'b0;
                        remain      <= req_len_q;
                    end
                end
                ST_STREAM: begin
                    if (load) begin
                        o_data_q  <= bus.fifo_data;
                        o_valid_q <= 1'b1;
                        o_last_q  <= (remain == 5'd1);
                        remain    <= remain - 5'd1;
                    end else if (o_valid_q && bus.o_ready) begin
                        o_valid_q <= 1'b0;
                        o_last_q  <= 1'b0;
                    end
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

    // req_valid is always high in ST_REQ, so req_ready alone completes the accept.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!bus.fifo_almost_empty ||
                    (bus.fifo_valid && timer == TIMEOUT_LAST)) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.req_ready) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (o_valid_q && bus.o_ready && o_last_q) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A pop during reset would lose a word the FIFO owner may not be flushing.
    always_comb begin
        load = 1'b0;
        if (state == ST_STREAM && reset && bus.fifo_valid && remain != 5'd0 &&
            (!o_valid_q || bus.o_ready)) begin
            load = 1'b1;
        end
        bus.fifo_read = load;
        bus.dbg_state = state;
    end

    assign bus.req_valid = req_valid_q;
    assign bus.req_len   = req_len_q;
    assign bus.o_data    = o_data_q;
    assign bus.o_valid   = o_valid_q;
    assign bus.o_last    = o_last_q;

`ifdef FIFO_BURST_READER_STATS_EN
    logic [31:0] stat_words_q;
    logic [31:0] stat_bursts_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_words_q  <= '0;
            stat_bursts_q <= '0;
        end else if (o_valid_q && bus.o_ready) begin
            stat_words_q <= stat_words_q + 32'd1;
            if (o_last_q) begin
                stat_bursts_q <= stat_bursts_q + 32'd1;
            end
        end
    end

    assign bus.stat_words  = stat_words_q;
    assign bus.stat_bursts = stat_bursts_q;
`else
    assign bus.stat_words  = 32'd0;
    assign bus.stat_bursts = 32'd0;
`endif
endmodule
